// File: rtl/exc_ctrl_mepc.sv
// exc_ctrl_mepc: exception/interrupt sequencer feeding the mEPC register and fetch redirect.
module exc_ctrl_mepc #(
   parameter int unsigned NrOfIrq = 4,
   parameter int unsigned AddrWidth = 32,
   parameter logic [AddrWidth-1:0] VectorBase = 32'h00000100
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 tick_i,
   input  logic [NrOfIrq-1:0]   irq_i,
   input  logic                 ecall_i,
   input  logic                 mret_i,
   input  logic [AddrWidth-1:0] pc_cur_i,
   input  logic                 boundary_i,
   input  logic [AddrWidth-1:0] mepc_q_i,
   output logic                 mepc_we_o,
   output logic [AddrWidth-1:0] mepc_d_o,
   output logic                 redirect_o,
   output logic [AddrWidth-1:0] redirect_pc_o,
   output logic                 stall_o,
   output logic [3:0]           cause_o,
   output logic                 in_handler_o
);
   typedef enum logic [2:0] {IDLE, SAVE, JUMP, HANDLER, RETURN} state_e;
   state_e state_q, state_d;
   logic [NrOfIrq-1:0] pend_q, pend_d, prev_q, rise, clr, avail;
   logic mie_q, mie_d, take;
   logic [3:0] cause_q, cause_d, irq_idx;
   logic [AddrWidth-1:0] spc_q, spc_d;

   // An edge arriving on the boundary cycle is taken at once, not a cycle later.
   assign rise  = irq_i & ~prev_q;
   assign avail = pend_q | rise;
   assign take  = mie_q && boundary_i && (ecall_i || |avail);
   assign clr   = (state_q == JUMP && 32'(cause_q) < NrOfIrq) ? NrOfIrq'(1) << cause_q : '0;
   assign pend_d = (pend_q & ~clr) | rise;

   always_comb begin
      irq_idx = '0;
      for (int i = NrOfIrq - 1; i >= 0; i--) if (avail[i]) irq_idx = 4'(i);
   end

   always_comb begin
      state_d = state_q;
      mie_d   = mie_q;
      cause_d = cause_q;
      spc_d   = spc_q;
      case (state_q)
         IDLE: if (take) begin
            state_d = SAVE;
            cause_d = ecall_i ? 4'(NrOfIrq) : irq_idx;
            spc_d   = ecall_i ? pc_cur_i + AddrWidth'(4) : pc_cur_i;
         end
         SAVE: state_d = JUMP;
         JUMP: begin
            state_d = HANDLER;
            mie_d   = 1'b0;
         end
         HANDLER: state_d = mret_i ? RETURN : HANDLER;
         RETURN: begin
            state_d = IDLE;
            mie_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pend_q  <= '0;
         prev_q  <= '0;
         mie_q   <= 1'b1;
         cause_q <= '0;
         spc_q   <= '0;
      end else if (tick_i) begin
         state_q <= state_d;
         pend_q  <= pend_d;
         prev_q  <= irq_i;
         mie_q   <= mie_d;
         cause_q <= cause_d;
         spc_q   <= spc_d;
      end
   end

   assign mepc_we_o     = state_q == SAVE;
   assign mepc_d_o      = mepc_we_o ? spc_q : '0;
   assign redirect_o    = state_q == JUMP || state_q == RETURN;
   assign redirect_pc_o = state_q == JUMP ? VectorBase + (AddrWidth'(cause_q) << 2) :
                          state_q == RETURN ? mepc_q_i : '0;
   assign stall_o       = state_q == SAVE || state_q == JUMP || state_q == RETURN;
   assign cause_o       = cause_q;
   assign in_handler_o  = state_q == JUMP || state_q == HANDLER;
endmodule

// File: tb/tb_exc_ctrl_mepc.sv
// tb_exc_ctrl_mepc: directed-vector bench for exc_ctrl_mepc with hand-computed expectations.
module tb_exc_ctrl_mepc;
   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b1, ecall = 1'b0, mret = 1'b0, boundary = 1'b0;
   logic [3:0] irq = '0;
   logic [31:0] pc = '0, mepc_q = '0;
   logic we, rd, st, ih;
   logic [31:0] d, rpc;
   logic [3:0] cause;
   int n_tests = 0, n_fail = 0;

   exc_ctrl_mepc dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .irq_i(irq), .ecall_i(ecall), .mret_i(mret),
      .pc_cur_i(pc), .boundary_i(boundary), .mepc_q_i(mepc_q), .mepc_we_o(we), .mepc_d_o(d),
      .redirect_o(rd), .redirect_pc_o(rpc), .stall_o(st), .cause_o(cause), .in_handler_o(ih)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic outs(input string tag, input logic e_we, input logic [31:0] e_d, input logic e_rd,
                       input logic [31:0] e_rpc, input logic e_st, input logic [3:0] e_c, input logic e_ih);
      check({tag, ".we"}, 32'(we), 32'(e_we));
      check({tag, ".d"}, d, e_d);
      check({tag, ".rd"}, 32'(rd), 32'(e_rd));
      check({tag, ".rpc"}, rpc, e_rpc);
      check({tag, ".stall"}, 32'(st), 32'(e_st));
      check({tag, ".cause"}, 32'(cause), 32'(e_c));
      check({tag, ".inh"}, 32'(ih), 32'(e_ih));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3 outs("rst", 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         outs("quiet", 0, 0, 0, 0, 0, 0, 0);
      end
      irq = 4'b0100; pc = 32'h40; boundary = 1'b1;
      step(); outs("irq2.save", 1, 32'h40, 0, 0, 1, 2, 0);
      boundary = 1'b0;
      step(); outs("irq2.jump", 0, 0, 1, 32'h108, 1, 2, 1);
      step(); outs("irq2.hdl", 0, 0, 0, 0, 0, 2, 1);
      mepc_q = 32'h1234; mret = 1'b1;
      step(); outs("irq2.ret", 0, 0, 1, 32'h1234, 1, 2, 0);
      mret = 1'b0;
      step(); outs("irq2.idle", 0, 0, 0, 0, 0, 2, 0);
      boundary = 1'b1;
      step(); outs("irq2.cleared", 0, 0, 0, 0, 0, 2, 0);
      irq = 4'b0001; ecall = 1'b1; pc = 32'h80;
      step(); outs("ecall.save", 1, 32'h84, 0, 0, 1, 4, 0);
      ecall = 1'b0; boundary = 1'b0;
      step(); outs("ecall.jump", 0, 0, 1, 32'h110, 1, 4, 1);
      step(); outs("ecall.hdl", 0, 0, 0, 0, 0, 4, 1);
      mepc_q = 32'h84; mret = 1'b1;
      step(); outs("ecall.ret", 0, 0, 1, 32'h84, 1, 4, 0);
      mret = 1'b0;
      step(); outs("ecall.idle", 0, 0, 0, 0, 0, 4, 0);
      boundary = 1'b1; pc = 32'h200;
      step(); outs("irq0.save", 1, 32'h200, 0, 0, 1, 0, 0);
      boundary = 1'b0;
      step(); outs("irq0.jump", 0, 0, 1, 32'h100, 1, 0, 1);
      step(); outs("irq0.hdl", 0, 0, 0, 0, 0, 0, 1);
      mepc_q = 32'h200; mret = 1'b1;
      step(); outs("irq0.ret", 0, 0, 1, 32'h200, 1, 0, 0);
      mret = 1'b0;
      step(); outs("irq0.idle", 0, 0, 0, 0, 0, 0, 0);
      irq = 4'b0011; pc = 32'h300; boundary = 1'b1;
      step(); outs("irq1.save", 1, 32'h300, 0, 0, 1, 1, 0);
      tick = 1'b0; boundary = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         outs("tickhold", 1, 32'h300, 0, 0, 1, 1, 0);
      end
      tick = 1'b1;
      step(); outs("irq1.jump", 0, 0, 1, 32'h104, 1, 1, 1);
      #2 rst_n = 1'b0; irq = 4'b0000;
      #1 outs("rst.jump", 0, 0, 0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1; boundary = 1'b1;
      step(); outs("rst.pendlost", 0, 0, 0, 0, 0, 0, 0);
      irq = 4'b1000; pc = 32'h500;
      step(); outs("irq3.save", 1, 32'h500, 0, 0, 1, 3, 0);
      boundary = 1'b0;
      step(); outs("irq3.jump", 0, 0, 1, 32'h10C, 1, 3, 1);
      step();
      mepc_q = 32'h500; mret = 1'b1;
      step(); outs("irq3.ret", 0, 0, 1, 32'h500, 1, 3, 0);
      mret = 1'b0;
      step(); outs("irq3.idle", 0, 0, 0, 0, 0, 3, 0);
      ecall = 1'b1; pc = 32'hFFFF_FFFC; boundary = 1'b1;
      step(); outs("wrap.save", 1, 32'h0, 0, 0, 1, 4, 0);
      ecall = 1'b0; boundary = 1'b0;
      step(); outs("wrap.jump", 0, 0, 1, 32'h110, 1, 4, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
